// File: rtl/alu_pkg.sv
// Opcode set and shared helpers for the multi-cycle ALU.
package alu_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SHL1 = 4'd2,
      OP_ASR1 = 4'd3,
      OP_LSR1 = 4'd4,
      OP_NOT  = 4'd5,
      OP_AND  = 4'd6,
      OP_XOR  = 4'd7,
      OP_RXOR = 4'd8,
      OP_SHLN = 4'd9,
      OP_LSRN = 4'd10,
      OP_MUL  = 4'd11,
      OP_CLRF = 4'd12
   } alu_op_e;

   // Opcodes that need the iterative datapath; values 13-15 fall through as NOPs.
   function automatic logic is_multi(input alu_op_e op);
      return (op == OP_SHLN) || (op == OP_LSRN) || (op == OP_MUL);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath: result plus next shift-carry and parity values.
module alu_core
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  alu_op_e      op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sc_in,
   input  logic         pari_in,
   output logic [W-1:0] r,
   output logic         c_out,
   output logic         p_out
);

   logic [W:0] sum;

   always_comb begin
      sum   = '0;
      r     = '0;
      c_out = sc_in;
      p_out = pari_in;
      case (op)
         OP_ADD: begin
            sum   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, sc_in};
            r     = sum[W-1:0];
            c_out = sum[W];
            p_out = 1'b0;
         end
         OP_SUB: begin
            sum   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, sc_in};
            r     = sum[W-1:0];
            c_out = sum[W];
            p_out = 1'b0;
         end
         OP_SHL1: begin
            r     = {a[W-2:0], sc_in};
            c_out = a[W-1];
            p_out = 1'b0;
         end
         OP_ASR1: begin
            r     = {a[W-1], a[W-1:1]};
            c_out = a[0];
            p_out = 1'b0;
         end
         OP_LSR1: begin
            r     = {sc_in, a[W-1:1]};
            c_out = a[0];
            p_out = 1'b0;
         end
         OP_NOT: begin
            r     = ~a;
            c_out = 1'b0;
         end
         OP_AND: begin
            r     = a & b;
            c_out = 1'b0;
         end
         OP_XOR: begin
            r     = a ^ b;
            c_out = 1'b0;
         end
         OP_RXOR: begin
            p_out = (^a) ^ pari_in;
            r     = {{(W-1){1'b0}}, p_out};
            c_out = 1'b0;
         end
         // Zero-length shifts finish here: operand passes through, carry kept.
         OP_SHLN, OP_LSRN: begin
            r     = a;
            p_out = 1'b0;
         end
         OP_CLRF: begin
            c_out = 1'b0;
            p_out = 1'b0;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// Clocked ALU with start/busy/done handshake, iterative shifts and shift-add multiply.
module alu_mc
   import alu_pkg::*;
#(
   parameter int W     = 8,
   parameter int CMD_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CMD_W-1:0] alu_cmd,
   input  logic [W-1:0]     inA,
   input  logic [W-1:0]     inB,
   output logic [W-1:0]     rslt,
   output logic             done,
   output logic             busy,
   output logic             sc_q,
   output logic             pari_q
);

   localparam int CNT_W = $clog2(W) + 1;
   localparam logic [W-1:0] W_VAL = W'(W);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e           state;
   alu_op_e          op_in;
   alu_op_e          op_q;
   logic [CNT_W-1:0] cnt;
   logic [2*W-1:0]   acc;
   logic [2*W-1:0]   prod;
   logic [W-1:0]     mplier;
   logic [2*W-1:0]   prod_nxt;
   logic [W-1:0]     shift_nxt;
   logic             shift_out;
   logic [W-1:0]     core_r;
   logic             core_c;
   logic             core_p;

   assign op_in = alu_op_e'(alu_cmd);

   alu_core #(.W(W)) u_core (
      .op      (op_in),
      .a       (inA),
      .b       (inB),
      .sc_in   (sc_q),
      .pari_in (pari_q),
      .r       (core_r),
      .c_out   (core_c),
      .p_out   (core_p)
   );

   // One step of the iterative datapath; acc is the shifted operand or multiplicand.
   always_comb begin
      prod_nxt  = mplier[0] ? (prod + acc) : prod;
      shift_nxt = '0;
      shift_out = 1'b0;
      if (op_q == OP_LSRN) begin
         shift_nxt = {1'b0, acc[W-1:1]};
         shift_out = acc[0];
      end else begin
         shift_nxt = {acc[W-2:0], 1'b0};
         shift_out = acc[W-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         op_q   <= OP_ADD;
         cnt    <= '0;
         acc    <= '0;
         prod   <= '0;
         mplier <= '0;
         rslt   <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
         sc_q   <= 1'b0;
         pari_q <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_RUN: begin
               cnt <= cnt - 1'b1;
               if (op_q == OP_MUL) begin
                  prod   <= prod_nxt;
                  acc    <= acc << 1;
                  mplier <= mplier >> 1;
               end else begin
                  acc <= {{W{1'b0}}, shift_nxt};
               end
               if (cnt == CNT_W'(1)) begin
                  state  <= S_DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  pari_q <= 1'b0;
                  if (op_q == OP_MUL) begin
                     rslt <= prod_nxt[W-1:0];
                     sc_q <= |prod_nxt[2*W-1:W];
                  end else begin
                     rslt <= shift_nxt;
                     sc_q <= shift_out;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               if (start) begin
                  if (is_multi(op_in) && !(op_in != OP_MUL && inB == '0)) begin
                     state  <= S_RUN;
                     busy   <= 1'b1;
                     op_q   <= op_in;
                     acc    <= {{W{1'b0}}, inA};
                     prod   <= '0;
                     mplier <= inB;
                     if (op_in == OP_MUL || inB >= W_VAL)
                        cnt <= CNT_W'(W);
                     else
                        cnt <= inB[CNT_W-1:0];
                  end else begin
                     state  <= S_DONE;
                     done   <= 1'b1;
                     rslt   <= core_r;
                     sc_q   <= core_c;
                     pari_q <= core_p;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at W=8 with hand-computed expectations.
module tb_alu_mc;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] alu_cmd;
   logic [7:0] inA;
   logic [7:0] inB;
   logic [7:0] rslt;
   logic       done;
   logic       busy;
   logic       sc_q;
   logic       pari_q;

   int checks = 0;
   int passes = 0;
   int lat;
   int busyCnt;
   bit sawDone;

   alu_mc #(.W(8), .CMD_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .alu_cmd (alu_cmd),
      .inA     (inA),
      .inB     (inB),
      .rslt    (rslt),
      .done    (done),
      .busy    (busy),
      .sc_q    (sc_q),
      .pari_q  (pari_q)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      else
         passes++;
   endtask

   // Launch one op and count edges until done; optionally spam start while busy.
   task automatic applyStimulus(input string tag, input logic [3:0] cmd, input logic [7:0] a,
                                input logic [7:0] b, input bit poke,
                                output int latency, output int busyCycles);
      @(negedge clk);
      alu_cmd = cmd;
      inA     = a;
      inB     = b;
      start   = 1'b1;
      latency    = 0;
      busyCycles = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         latency++;
         if (busy) busyCycles++;
         if (poke) begin
            start   = 1'b1;
            alu_cmd = 4'd0;
            inA     = 8'($urandom);
            inB     = 8'($urandom);
         end
      end while (!done && latency < 40);
      start = 1'b0;
      checkOutput({tag, "_done"}, 32'(done), 32'd1);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      alu_cmd = '0;
      inA     = '0;
      inB     = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_rslt", 32'(rslt), 32'h0);
      checkOutput("rst_done", 32'(done), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_sc", 32'(sc_q), 32'h0);
      checkOutput("rst_pari", 32'(pari_q), 32'h0);

      // ADD with carry out, then carry folded into the next ADD
      applyStimulus("add1", 4'd0, 8'hF0, 8'h20, 1'b0, lat, busyCnt);
      checkOutput("add1_lat", 32'(lat), 32'd1);
      checkOutput("add1_rslt", 32'(rslt), 32'h10);
      checkOutput("add1_sc", 32'(sc_q), 32'h1);
      applyStimulus("add2", 4'd0, 8'h01, 8'h01, 1'b0, lat, busyCnt);
      checkOutput("add2_rslt", 32'(rslt), 32'h03);
      checkOutput("add2_sc", 32'(sc_q), 32'h0);

      // CLRF, seed carry via SHL1, then A-B with borrow
      applyStimulus("clrf", 4'd12, 8'hAA, 8'h55, 1'b0, lat, busyCnt);
      checkOutput("clrf_rslt", 32'(rslt), 32'h0);
      checkOutput("clrf_sc", 32'(sc_q), 32'h0);
      applyStimulus("shl1", 4'd2, 8'h80, 8'h00, 1'b0, lat, busyCnt);
      checkOutput("shl1_rslt", 32'(rslt), 32'h00);
      checkOutput("shl1_sc", 32'(sc_q), 32'h1);
      applyStimulus("sub", 4'd1, 8'h05, 8'h07, 1'b0, lat, busyCnt);
      checkOutput("sub_rslt", 32'(rslt), 32'hFE);
      checkOutput("sub_sc", 32'(sc_q), 32'h0);

      // Parity accumulation, then AND keeps parity
      applyStimulus("rxor1", 4'd8, 8'h07, 8'h00, 1'b0, lat, busyCnt);
      checkOutput("rxor1_rslt", 32'(rslt), 32'h1);
      checkOutput("rxor1_pari", 32'(pari_q), 32'h1);
      applyStimulus("rxor2", 4'd8, 8'h07, 8'h00, 1'b0, lat, busyCnt);
      checkOutput("rxor2_rslt", 32'(rslt), 32'h0);
      checkOutput("rxor2_pari", 32'(pari_q), 32'h0);
      applyStimulus("rxor3", 4'd8, 8'h01, 8'h00, 1'b0, lat, busyCnt);
      applyStimulus("and", 4'd6, 8'hF0, 8'h3C, 1'b0, lat, busyCnt);
      checkOutput("and_rslt", 32'(rslt), 32'h30);
      checkOutput("and_pari", 32'(pari_q), 32'h1);
      checkOutput("and_sc", 32'(sc_q), 32'h0);

      // Remaining single-cycle ops
      applyStimulus("asr1", 4'd3, 8'h81, 8'h00, 1'b0, lat, busyCnt);
      checkOutput("asr1_rslt", 32'(rslt), 32'hC0);
      checkOutput("asr1_sc", 32'(sc_q), 32'h1);
      checkOutput("asr1_pari", 32'(pari_q), 32'h0);
      applyStimulus("lsr1", 4'd4, 8'h02, 8'h00, 1'b0, lat, busyCnt);
      checkOutput("lsr1_rslt", 32'(rslt), 32'h81);
      checkOutput("lsr1_sc", 32'(sc_q), 32'h0);
      applyStimulus("not", 4'd5, 8'h0F, 8'h00, 1'b0, lat, busyCnt);
      checkOutput("not_rslt", 32'(rslt), 32'hF0);
      applyStimulus("xor", 4'd7, 8'hFF, 8'h0F, 1'b0, lat, busyCnt);
      checkOutput("xor_rslt", 32'(rslt), 32'hF0);
      applyStimulus("nop", 4'd14, 8'hFF, 8'hFF, 1'b0, lat, busyCnt);
      checkOutput("nop_rslt", 32'(rslt), 32'h00);

      // Multi-cycle shifts, including the clamp and the zero-count case
      applyStimulus("shln3", 4'd9, 8'h81, 8'd3, 1'b0, lat, busyCnt);
      checkOutput("shln3_lat", 32'(lat), 32'd4);
      checkOutput("shln3_busy", 32'(busyCnt), 32'd3);
      checkOutput("shln3_rslt", 32'(rslt), 32'h08);
      checkOutput("shln3_sc", 32'(sc_q), 32'h0);
      applyStimulus("lsrn9", 4'd10, 8'h81, 8'd9, 1'b0, lat, busyCnt);
      checkOutput("lsrn9_lat", 32'(lat), 32'd9);
      checkOutput("lsrn9_busy", 32'(busyCnt), 32'd8);
      checkOutput("lsrn9_rslt", 32'(rslt), 32'h00);
      checkOutput("lsrn9_sc", 32'(sc_q), 32'h1);
      applyStimulus("shln0", 4'd9, 8'h5A, 8'd0, 1'b0, lat, busyCnt);
      checkOutput("shln0_lat", 32'(lat), 32'd1);
      checkOutput("shln0_rslt", 32'(rslt), 32'h5A);
      checkOutput("shln0_sc", 32'(sc_q), 32'h1);

      // Multiply with overflow while start is hammered during busy
      applyStimulus("mul", 4'd11, 8'h10, 8'h11, 1'b1, lat, busyCnt);
      checkOutput("mul_lat", 32'(lat), 32'd9);
      checkOutput("mul_busy", 32'(busyCnt), 32'd8);
      checkOutput("mul_rslt", 32'(rslt), 32'h10);
      checkOutput("mul_sc", 32'(sc_q), 32'h1);
      applyStimulus("mul2", 4'd11, 8'h0D, 8'h0B, 1'b0, lat, busyCnt);
      checkOutput("mul2_rslt", 32'(rslt), 32'h8F);
      checkOutput("mul2_sc", 32'(sc_q), 32'h0);
      applyStimulus("mul3", 4'd11, 8'hFF, 8'hFF, 1'b0, lat, busyCnt);
      checkOutput("mul3_rslt", 32'(rslt), 32'h01);
      checkOutput("mul3_sc", 32'(sc_q), 32'h1);

      // Reset in the middle of a multiply aborts it silently
      @(negedge clk);
      alu_cmd = 4'd11;
      inA     = 8'h33;
      inB     = 8'h44;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort_rslt", 32'(rslt), 32'h0);
      checkOutput("abort_done", 32'(done), 32'h0);
      checkOutput("abort_busy", 32'(busy), 32'h0);
      checkOutput("abort_sc", 32'(sc_q), 32'h0);
      checkOutput("abort_pari", 32'(pari_q), 32'h0);
      sawDone = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done) sawDone = 1'b1;
      end
      checkOutput("abort_nodone", 32'(sawDone), 32'h0);

      // Back-to-back ADDs: second start accepted in the DONE cycle
      alu_cmd = 4'd0;
      inA     = 8'h03;
      inB     = 8'h04;
      start   = 1'b1;
      @(negedge clk);
      checkOutput("b2b1_done", 32'(done), 32'h1);
      checkOutput("b2b1_rslt", 32'(rslt), 32'h07);
      inA = 8'h10;
      inB = 8'h01;
      @(negedge clk);
      start = 1'b0;
      checkOutput("b2b2_done", 32'(done), 32'h1);
      checkOutput("b2b2_rslt", 32'(rslt), 32'h11);
      @(negedge clk);
      checkOutput("b2b_idle_done", 32'(done), 32'h0);
      checkOutput("b2b_hold_rslt", 32'(rslt), 32'h11);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
